alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 9 +
 rtl/alu_muldiv.sv | 52 +++++
 rtl/alu.sv | 118 +++++++++++
 tb/tb_alu.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM states and multiply/divide step count shared by the ALU files
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_AND, OP_OR, OP_XOR, OP_NOT,
    OP_SHL, OP_SHR, OP_MUL, OP_MULH, OP_DIV, OP_MOD, OP_PASS, OP_CMP
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  localparam int MULDIV_STEPS = 8;
endpackage

// File: rtl/alu_muldiv.sv
// alu_muldiv: 8-step shift-add multiplier / restoring divider (start,div,a,b -> busy,product,quotient,remainder,div0,valid)
module alu_muldiv
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        div,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic [15:0] product,
  output logic [7:0]  quotient,
  output logic [7:0]  remainder,
  output logic        div0,
  output logic        valid
);
  logic        mode;
  logic [7:0]  a_r, b_r;
  logic [15:0] w, w_n;
  logic [2:0]  cnt;
  logic [8:0]  msum, t;
  logic        ge;
  always_comb begin
    msum = {1'b0, w[15:8]} + {1'b0, w[0] ? a_r : 8'd0};
    t    = {w[15:8], w[7]};
    ge   = t >= {1'b0, b_r};
    w_n  = mode ? {ge ? 8'(t - {1'b0, b_r}) : t[7:0], w[6:0], ge} : {msum, w[7:1]};
  end
  assign product   = w_n;
  assign quotient  = w_n[7:0];
  assign remainder = w_n[15:8];
  assign valid     = busy && cnt == 3'(MULDIV_STEPS - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      mode <= div;
      a_r  <= a;
      b_r  <= b;
      div0 <= b == 8'd0;
      w    <= {8'd0, div ? a : b};
    end else if (busy) begin
      w    <= w_n;
      cnt  <= cnt + 3'd1;
      busy <= !valid;
    end
  end
endmodule

// File: rtl/alu.sv
// alu: 8-bit ALU, single-cycle arith/logic plus 8-step mul/div (clk,rst,start,op,a,b,cin -> result,carry,overflow,done,busy,flags_we)
module alu
  import alu_pkg::*;
#(
  parameter bit FLAGS_ON_LOGIC = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] result,
  output logic       carry,
  output logic       overflow,
  output logic       done,
  output logic       busy,
  output logic       flags_we
);
  state_e      state;
  logic [3:0]  op_r;
  logic        accept, is_md, is_logic;
  logic [8:0]  sum, dif;
  logic [7:0]  sc_res;
  logic        sc_c, sc_v;
  logic [15:0] md_p;
  logic [7:0]  md_q, md_r;
  logic        md_div0, md_valid;
  assign accept   = start && state != S_RUN;
  assign is_md    = op inside {OP_MUL, OP_MULH, OP_DIV, OP_MOD};
  assign is_logic = op inside {OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR, OP_PASS};
  assign sum      = {1'b0, a} + {1'b0, b} + {8'd0, op == OP_ADC && cin};
  assign dif      = {1'b0, a} - {1'b0, b} - {8'd0, op == OP_SBB && cin};
  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (op_e'(op))
      OP_ADD, OP_ADC: begin
        sc_res = sum[7:0];
        sc_c   = sum[8];
        sc_v   = a[7] == b[7] && sum[7] != a[7];
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        sc_res = dif[7:0];
        sc_c   = dif[8];
        sc_v   = a[7] != b[7] && dif[7] != a[7];
      end
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_NOT:  sc_res = ~a;
      OP_SHL: begin
        sc_res = {a[6:0], 1'b0};
        sc_c   = a[7];
      end
      OP_SHR: begin
        sc_res = {1'b0, a[7:1]};
        sc_c   = a[0];
      end
      OP_PASS: sc_res = a;
      default: ;
    endcase
  end
  alu_muldiv u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && is_md),
    .div       (op[2]),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .product   (md_p),
    .quotient  (md_q),
    .remainder (md_r),
    .div0      (md_div0),
    .valid     (md_valid)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_r     <= '0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
      flags_we <= 1'b0;
    end else begin
      done     <= 1'b0;
      flags_we <= 1'b0;
      if (accept) begin
        op_r <= op;
        if (is_md) begin
          state <= S_RUN;
        end else begin
          state    <= S_DONE;
          result   <= sc_res;
          carry    <= sc_c;
          overflow <= sc_v;
          done     <= 1'b1;
          flags_we <= !is_logic || FLAGS_ON_LOGIC;
        end
      end else if (state == S_RUN) begin
        if (md_valid) begin
          state    <= S_DONE;
          result   <= op_r == OP_MUL ? md_p[7:0] : op_r == OP_MULH ? md_p[15:8] : op_r == OP_DIV ? md_q : md_r;
          carry    <= op_r[2] ? md_div0 : |md_p[15:8];
          overflow <= op_r[2] ? md_div0 : |md_p[15:8];
          done     <= 1'b1;
          flags_we <= 1'b1;
        end
      end else if (state == S_DONE) begin
        state <= S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed scoreboard bench for alu with default and FLAGS_ON_LOGIC=0 instances
module tb_alu;
  import alu_pkg::*;
  typedef struct {
    logic [7:0] res;
    logic       c, v, fwe1, fwe0;
    int         lat;
  } exp_t;
  logic       clk = 1'b0, rst, start, cin;
  logic [3:0] op;
  logic [7:0] a, b, result, result0;
  logic       carry, overflow, done, busy, flags_we;
  logic       carry0, overflow0, done0, busy0, flags_we0;
  int         checks = 0, errors = 0, cyc = 0, t0 = 0;
  exp_t       sb[$];
  alu dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .result(result), .carry(carry), .overflow(overflow), .done(done), .busy(busy), .flags_we(flags_we)
  );
  alu #(.FLAGS_ON_LOGIC(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .result(result0), .carry(carry0), .overflow(overflow0), .done(done0), .busy(busy0), .flags_we(flags_we0)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  function automatic exp_t model(logic [3:0] o, logic [7:0] x, logic [7:0] y, logic c);
    exp_t e;
    int ai, bi, sa, sb, ci, r, sr;
    ai = int'(x);
    bi = int'(y);
    sa = int'($signed(x));
    sb = int'($signed(y));
    ci = (o == OP_ADC || o == OP_SBB) ? int'(c) : 0;
    e = '{res: 8'h00, c: 1'b0, v: 1'b0, fwe1: 1'b1, fwe0: 1'b1, lat: 1};
    case (o)
      OP_ADD, OP_ADC: begin
        r = ai + bi + ci; sr = sa + sb + ci;
        e.res = 8'(r); e.c = r > 255; e.v = sr > 127 || sr < -128;
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        r = ai - bi - ci; sr = sa - sb - ci;
        e.res = 8'(r); e.c = r < 0; e.v = sr > 127 || sr < -128;
      end
      OP_AND:  e.res = x & y;
      OP_OR:   e.res = x | y;
      OP_XOR:  e.res = x ^ y;
      OP_NOT:  e.res = ~x;
      OP_SHL:  begin e.res = 8'(ai * 2); e.c = x[7]; end
      OP_SHR:  begin e.res = 8'(ai / 2); e.c = x[0]; end
      OP_PASS: e.res = x;
      OP_MUL, OP_MULH: begin
        r = ai * bi;
        e.res = o == OP_MUL ? 8'(r) : 8'(r / 256);
        e.c = r > 255; e.v = r > 255;
      end
      default: begin
        if (bi == 0) begin
          e.res = o == OP_DIV ? 8'hFF : x; e.c = 1'b1; e.v = 1'b1;
        end else begin
          e.res = o == OP_DIV ? 8'(ai / bi) : 8'(ai % bi);
        end
      end
    endcase
    if (o inside {OP_MUL, OP_MULH, OP_DIV, OP_MOD}) e.lat = 9;
    if (o inside {OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR, OP_PASS}) e.fwe0 = 1'b0;
    return e;
  endfunction
  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic go(logic [3:0] o, logic [7:0] x, logic [7:0] y, logic c, bit push);
    op = o; a = x; b = y; cin = c; start = 1'b1;
    if (push) begin
      sb.push_back(model(o, x, y, c));
      t0 = cyc;
    end
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    cin = 1'($urandom);
  endtask
  task automatic wait_done(string tag, output logic [7:0] res);
    exp_t e;
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " done"}, 16'(done), 16'd1);
    res = 8'hxx;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 16'(sb.size()), 16'd1);
    end else begin
      e = sb.pop_front();
      res = e.res;
      chk({tag, " latency"}, 16'(cyc - t0), 16'(e.lat));
      chk({tag, " result"}, 16'(result), 16'(e.res));
      chk({tag, " carry"}, 16'(carry), 16'(e.c));
      chk({tag, " overflow"}, 16'(overflow), 16'(e.v));
      chk({tag, " flags_we"}, 16'(flags_we), 16'(e.fwe1));
      chk({tag, " result0"}, 16'(result0), 16'(e.res));
      chk({tag, " done0"}, 16'(done0), 16'd1);
      chk({tag, " flags_we0"}, 16'(flags_we0), 16'(e.fwe0));
    end
  endtask
  task automatic run(string tag, logic [3:0] o, logic [7:0] x, logic [7:0] y, logic c);
    logic [7:0] res;
    go(o, x, y, c, 1'b1);
    wait_done(tag, res);
    @(negedge clk);
    chk({tag, " done pulse"}, 16'(done), 16'd0);
    chk({tag, " flags_we pulse"}, 16'(flags_we), 16'd0);
    chk({tag, " result hold"}, 16'(result), 16'(res));
  endtask
  initial begin
    logic [7:0] r;
    logic seen;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset result", 16'(result), 16'h00);
    chk("reset carry", 16'(carry), 16'd0);
    chk("reset overflow", 16'(overflow), 16'd0);
    chk("reset done", 16'(done), 16'd0);
    chk("reset busy", 16'(busy), 16'd0);
    chk("reset flags_we", 16'(flags_we), 16'd0);
    rst = 1'b0;
    @(negedge clk);
    run("add", OP_ADD, 8'h7F, 8'h01, 1'b0);
    run("adc", OP_ADC, 8'hFF, 8'h00, 1'b1);
    run("sub", OP_SUB, 8'h00, 8'h01, 1'b1);
    run("cmp", OP_CMP, 8'h00, 8'h01, 1'b0);
    run("sbb", OP_SBB, 8'h80, 8'h00, 1'b1);
    run("or", OP_OR, 8'hA0, 8'h05, 1'b0);
    run("xor", OP_XOR, 8'hFF, 8'h0F, 1'b0);
    run("not", OP_NOT, 8'h5A, 8'h00, 1'b0);
    run("shl", OP_SHL, 8'h81, 8'h00, 1'b0);
    run("shr", OP_SHR, 8'h81, 8'h00, 1'b0);
    run("pass", OP_PASS, 8'h3C, 8'h99, 1'b0);
    run("mul", OP_MUL, 8'h10, 8'h20, 1'b0);
    run("mulh", OP_MULH, 8'h10, 8'h20, 1'b0);
    run("mul ff", OP_MUL, 8'hFF, 8'hFF, 1'b0);
    run("mulh ff", OP_MULH, 8'hFF, 8'hFF, 1'b0);
    run("mul small", OP_MUL, 8'h03, 8'h05, 1'b0);
    run("div", OP_DIV, 8'h64, 8'h07, 1'b0);
    run("mod", OP_MOD, 8'h64, 8'h07, 1'b0);
    run("div0", OP_DIV, 8'h37, 8'h00, 1'b0);
    run("mod0", OP_MOD, 8'h37, 8'h00, 1'b0);
    go(OP_AND, 8'hF0, 8'h3C, 1'b0, 1'b1);
    wait_done("and", r);
    go(OP_ADD, 8'h01, 8'h02, 1'b0, 1'b1);
    wait_done("b2b add", r);
    go(OP_MUL, 8'h0C, 8'h0B, 1'b0, 1'b1);
    wait_done("b2b mul", r);
    @(negedge clk);
    go(OP_DIV, 8'h64, 8'h07, 1'b0, 1'b1);
    @(negedge clk);
    go(OP_ADD, 8'h01, 8'h01, 1'b0, 1'b0);
    chk("ignored start busy", 16'(busy), 16'd1);
    wait_done("div ignore", r);
    @(negedge clk);
    go(OP_MUL, 8'h0F, 8'h0F, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    op = OP_ADD;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("abort result", 16'(result), 16'h00);
    chk("abort carry", 16'(carry), 16'd0);
    chk("abort overflow", 16'(overflow), 16'd0);
    chk("abort busy", 16'(busy), 16'd0);
    chk("abort done", 16'(done), 16'd0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | done | flags_we;
    end
    chk("abort no done", 16'(seen), 16'd0);
    run("after abort", OP_SUB, 8'h05, 8'h03, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
